// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encoding, control word and opcode map.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LDI, S_MVR, S_RTYPE, S_RTYPE_WB, S_FETCH2, S_LD_MEM,
    S_LDA, S_ALU_MEM, S_MEM_WB, S_STA, S_JMP, S_ILLEGAL, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    RF_SRC_NONE = 2'd0, RF_SRC_ALU = 2'd1, RF_SRC_REG1 = 2'd2, RF_SRC_TR = 2'd3
  } rf_src_t;

  typedef enum logic [1:0] {
    ALU_SRC_NONE = 2'd0, ALU_SRC_REG1 = 2'd1, ALU_SRC_TR = 2'd2
  } alu_src_t;

  localparam logic PC_SEL_INC   = 1'b0;
  localparam logic PC_SEL_JUMP  = 1'b1;
  localparam logic CZN_SRC_ALU  = 1'b0;
  localparam logic CZN_SRC_RF   = 1'b1;
  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_TR  = 1'b1;
  localparam logic ALU_OP_ADD   = 1'b0;
  localparam logic ALU_OP_AND   = 1'b1;

  // alu_op distinguishes the add/and flavours of the R-type and memory ALU instructions
  typedef struct packed {
    logic     ld_pc;
    logic     pc_sel;
    logic     ld_ir;
    logic     ld_di;
    logic     ld_tr;
    logic     ld_alu;
    logic     ld_czn;
    logic     czn_src;
    logic     rf_we;
    rf_src_t  rf_src;
    alu_src_t alu_src;
    logic     alu_op;
    logic     mem_addr_sel;
    logic     mem_rd;
    logic     mem_wr;
  } ctrl_t;

  localparam logic [2:0] OP3_LDI = 3'b000;
  localparam logic [2:0] OP3_LDA = 3'b001;
  localparam logic [2:0] OP3_STA = 3'b010;
  localparam logic [2:0] OP3_ADA = 3'b011;
  localparam logic [2:0] OP3_ANA = 3'b100;
  localparam logic [2:0] OP3_JMP = 3'b101;
  localparam logic [3:0] OP4_MVR = 4'b1100;
  localparam logic [3:0] OP4_ADR = 4'b1101;
  localparam logic [3:0] OP4_ANR = 4'b1110;
  localparam logic [3:0] OP4_ILL = 4'b1111;

endpackage

// File: rtl/multicycle_ctrl_hs_wait_timer.sv
// Consecutive memory wait-cycle counter; timeout is high once WAIT_MAX waits have accumulated.
// Saturates at the limit so the count cannot wrap while the FSM moves to ERROR.
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  logic [WCNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == WCNT_W'(WAIT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle CPU control FSM with memory req/ready handshake, wait timeout and sticky error.
// Optional CTRL_SINGLE_STEP_EN adds step_mode/step ports to park FETCH between instructions.
module multicycle_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W  = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               jump_cond,
  input  logic               mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output ctrl_t              ctrl,
  output state_t             state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               err
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_d;
  logic       alu_op_q, alu_op_d;
  logic       done_d;
  logic       wait_cyc;
  logic       timeout;
  logic       parked;
  logic [3:0] op;

  assign op = instr[INSTR_W-1 -: 4];

`ifdef CTRL_SINGLE_STEP_EN
  logic run_q, run_d;

  assign parked = step_mode && !run_q;

  // A step pulse only arms while parked; the armed flag drops when the instruction finishes.
  always_comb begin
    run_d = run_q;
    if (state_q == S_FETCH && parked && step) run_d = 1'b1;
    if (done_d) run_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= run_d;
  end
`else
  assign parked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = '0;
    done_d   = 1'b0;
    alu_op_d = alu_op_q;
    wait_cyc = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!parked) begin
          ctrl_d.mem_rd       = 1'b1;
          ctrl_d.mem_addr_sel = ADDR_SEL_PC;
          if (mem_ready) begin
            ctrl_d.ld_ir  = 1'b1;
            ctrl_d.ld_pc  = 1'b1;
            ctrl_d.pc_sel = PC_SEL_INC;
            state_d       = S_DECODE;
          end else begin
            wait_cyc = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (op == OP4_ILL) begin
          state_d = S_ILLEGAL;
        end else if (op == OP4_MVR) begin
          state_d = S_MVR;
        end else if (op == OP4_ADR || op == OP4_ANR) begin
          state_d  = S_RTYPE;
          alu_op_d = (op == OP4_ANR) ? ALU_OP_AND : ALU_OP_ADD;
        end else if (op[3:1] == OP3_LDI) begin
          state_d = S_LDI;
        end else begin
          state_d = S_FETCH2;
        end
      end
      S_LDI: begin
        ctrl_d.ld_di = 1'b1;
        done_d       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MVR: begin
        ctrl_d.rf_we   = 1'b1;
        ctrl_d.rf_src  = RF_SRC_REG1;
        ctrl_d.ld_czn  = 1'b1;
        ctrl_d.czn_src = CZN_SRC_ALU;
        done_d         = 1'b1;
        state_d        = S_FETCH;
      end
      S_RTYPE: begin
        ctrl_d.ld_alu  = 1'b1;
        ctrl_d.alu_src = ALU_SRC_REG1;
        ctrl_d.alu_op  = alu_op_q;
        ctrl_d.ld_czn  = 1'b1;
        ctrl_d.czn_src = CZN_SRC_ALU;
        state_d        = S_RTYPE_WB;
      end
      S_RTYPE_WB, S_MEM_WB: begin
        ctrl_d.rf_we  = 1'b1;
        ctrl_d.rf_src = RF_SRC_ALU;
        done_d        = 1'b1;
        state_d       = S_FETCH;
      end
      S_FETCH2: begin
        ctrl_d.mem_rd       = 1'b1;
        ctrl_d.mem_addr_sel = ADDR_SEL_PC;
        if (mem_ready) begin
          ctrl_d.ld_tr  = 1'b1;
          ctrl_d.ld_pc  = 1'b1;
          ctrl_d.pc_sel = PC_SEL_INC;
          case (op[3:1])
            OP3_LDA, OP3_ADA, OP3_ANA: state_d = S_LD_MEM;
            OP3_STA:                   state_d = S_STA;
            OP3_JMP:                   state_d = S_JMP;
            default:                   state_d = S_ILLEGAL;
          endcase
        end else begin
          wait_cyc = 1'b1;
        end
      end
      S_LD_MEM: begin
        ctrl_d.mem_rd       = 1'b1;
        ctrl_d.mem_addr_sel = ADDR_SEL_TR;
        if (mem_ready) begin
          ctrl_d.ld_tr = 1'b1;
          if (op[3:1] == OP3_LDA) begin
            state_d = S_LDA;
          end else begin
            state_d  = S_ALU_MEM;
            alu_op_d = (op[3:1] == OP3_ANA) ? ALU_OP_AND : ALU_OP_ADD;
          end
        end else begin
          wait_cyc = 1'b1;
        end
      end
      S_LDA: begin
        ctrl_d.rf_we   = 1'b1;
        ctrl_d.rf_src  = RF_SRC_TR;
        ctrl_d.ld_czn  = 1'b1;
        ctrl_d.czn_src = CZN_SRC_RF;
        done_d         = 1'b1;
        state_d        = S_FETCH;
      end
      S_ALU_MEM: begin
        ctrl_d.ld_alu  = 1'b1;
        ctrl_d.alu_src = ALU_SRC_TR;
        ctrl_d.alu_op  = alu_op_q;
        ctrl_d.ld_czn  = 1'b1;
        ctrl_d.czn_src = CZN_SRC_ALU;
        state_d        = S_MEM_WB;
      end
      S_STA: begin
        ctrl_d.mem_wr       = 1'b1;
        ctrl_d.mem_addr_sel = ADDR_SEL_TR;
        if (mem_ready) begin
          done_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_cyc = 1'b1;
        end
      end
      S_JMP: begin
        ctrl_d.ld_pc  = jump_cond;
        ctrl_d.pc_sel = jump_cond ? PC_SEL_JUMP : PC_SEL_INC;
        done_d        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ILLEGAL: begin
        done_d  = 1'b1;
        state_d = S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // A ready arriving on the limit cycle is not a wait cycle, so it advances normally.
    if (wait_cyc && timeout) state_d = S_ERROR;
  end

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (wait_cyc),
    .clr     (!wait_cyc),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      alu_op_q <= ALU_OP_ADD;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Control word is forced quiet while reset is held so no fetch request leaks out.
  assign ctrl       = rst ? '0 : ctrl_d;
  assign state      = state_q;
  assign instr_done = done_d;
  assign illegal_op = (state_q == S_ILLEGAL);
  assign err        = (state_q == S_ERROR);

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Bench for multicycle_ctrl_hs: directed handshake/timeout/reset cases, then random instructions
// against a per-instruction expectation table, checked by a scoreboard monitor on instr_done.
module tb_multicycle_ctrl_hs;
  import mc_ctrl_pkg::*;

  localparam int IW = 6;
  localparam int WM = 5;
  localparam int NI = 120;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] instr = '0;
  logic          jump_cond = 1'b0;
  logic          dir_ready = 1'b0;
  logic          mm_ready = 1'b0;
  logic          mm_en = 1'b0;
  logic          mon_en = 1'b0;
  logic          mem_ready;
  ctrl_t         ctrl;
  state_t        state;
  logic          instr_done, illegal_op, err;

  int n_vec = 0;
  int n_err = 0;

  assign mem_ready = mm_en ? mm_ready : dir_ready;

  always #5 clk = ~clk;

  multicycle_ctrl_hs #(.INSTR_W(IW), .WAIT_MAX(WM)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .jump_cond  (jump_cond),
    .mem_ready  (mem_ready),
    .ctrl       (ctrl),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .err        (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int lat; int rf_we; int ld_pc; int ld_tr; int ld_alu; int alu_and; int ld_di; int ill;
  } exp_t;

  exp_t expq[$];
  int   wq[$];

  logic [3:0] optab [11] = '{4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010,
                             4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0001};

  // Expected per-instruction totals from the ISA description: cycles and strobe counts.
  function automatic exp_t model(input logic [3:0] op, input logic jc, input int wsum);
    exp_t e;
    e = '{default: 0};
    e.ld_pc = 1;
    casez (op)
      4'b000?: begin e.lat = 3; e.ld_di = 1; end
      4'b001?: begin e.lat = 5; e.rf_we = 1; e.ld_tr = 2; e.ld_pc = 2; end
      4'b010?: begin e.lat = 4; e.ld_tr = 1; e.ld_pc = 2; end
      4'b011?: begin e.lat = 6; e.rf_we = 1; e.ld_tr = 2; e.ld_pc = 2; e.ld_alu = 1; end
      4'b100?: begin e.lat = 6; e.rf_we = 1; e.ld_tr = 2; e.ld_pc = 2; e.ld_alu = 1; e.alu_and = 1; end
      4'b101?: begin e.lat = 4; e.ld_tr = 1; e.ld_pc = 2 + int'(jc); end
      4'b1100: begin e.lat = 3; e.rf_we = 1; end
      4'b1101: begin e.lat = 4; e.rf_we = 1; e.ld_alu = 1; end
      4'b1110: begin e.lat = 4; e.rf_we = 1; e.ld_alu = 1; e.alu_and = 1; end
      default: begin e.lat = 3; e.ill = 1; end
    endcase
    e.lat += wsum;
    return e;
  endfunction

  function automatic int n_access(input logic [3:0] op);
    casez (op)
      4'b001?, 4'b010?, 4'b011?, 4'b100?: return 3;
      4'b101?:                            return 2;
      default:                            return 1;
    endcase
  endfunction

  task automatic issue();
    logic [3:0] op;
    logic       jc;
    int         w, wsum;
    #1;
    op = optab[$urandom_range(0, 10)];
    if (op[3:2] != 2'b11) op[0] = 1'($urandom);
    jc = 1'($urandom);
    wsum = 0;
    for (int a = 0; a < n_access(op); a++) begin
      w = ($urandom_range(0, 2) == 0) ? $urandom_range(0, WM) : 0;
      wq.push_back(w);
      wsum += w;
    end
    expq.push_back(model(op, jc, wsum));
    instr = {op, 2'($urandom)};
    jump_cond = jc;
  endtask

  task automatic wait_done();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!instr_done && c < 200);
    if (!instr_done) chk("done_timeout", 0, 1);
  endtask

  // Responsive memory: each access takes the next wait count from wq, then returns ready.
  int  mm_rem = 0;
  bit  mm_busy = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (mm_en && (ctrl.mem_rd || ctrl.mem_wr)) begin
      if (!mm_busy) begin
        mm_busy = 1'b1;
        mm_rem = (wq.size() > 0) ? wq.pop_front() : 0;
      end
      if (mm_rem > 0) begin
        mm_ready = 1'b0;
        mm_rem--;
      end else begin
        mm_ready = 1'b1;
        mm_busy = 1'b0;
      end
    end else begin
      mm_ready = 1'($urandom);
    end
  end

  int   m_lat = 0, m_rf = 0, m_pc = 0, m_tr = 0, m_alu = 0, m_and = 0, m_di = 0, m_ill = 0;
  exp_t m_e;
  always @(negedge clk) begin
    if (mon_en) begin
      m_lat++;
      m_rf  += int'(ctrl.rf_we);
      m_pc  += int'(ctrl.ld_pc);
      m_tr  += int'(ctrl.ld_tr);
      m_alu += int'(ctrl.ld_alu);
      m_and += int'(ctrl.ld_alu && ctrl.alu_op);
      m_di  += int'(ctrl.ld_di);
      m_ill += int'(illegal_op);
      if (instr_done) begin
        if (expq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          m_e = expq.pop_front();
          chk("sb_latency", m_lat, m_e.lat);
          chk("sb_rf_we", m_rf, m_e.rf_we);
          chk("sb_ld_pc", m_pc, m_e.ld_pc);
          chk("sb_ld_tr", m_tr, m_e.ld_tr);
          chk("sb_ld_alu", m_alu, m_e.ld_alu);
          chk("sb_alu_and", m_and, m_e.alu_and);
          chk("sb_ld_di", m_di, m_e.ld_di);
          chk("sb_illegal", m_ill, m_e.ill);
          chk("sb_err", int'(err), 0);
        end
        m_lat = 0; m_rf = 0; m_pc = 0; m_tr = 0; m_alu = 0; m_and = 0; m_di = 0; m_ill = 0;
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), int'(S_FETCH));
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_done", int'(instr_done), 0);
    chk("rst_illegal", int'(illegal_op), 0);
    chk("rst_err", int'(err), 0);

    // LDI with zero-wait memory: 3 cycles
    dir_ready = 1'b1;
    instr = {4'b0000, 2'b11};
    rst = 1'b0;
    #1;
    chk("ldi_c1_state", int'(state), int'(S_FETCH));
    chk("ldi_c1_ld_ir", int'(ctrl.ld_ir), 1);
    chk("ldi_c1_mem_rd", int'(ctrl.mem_rd), 1);
    @(negedge clk);
    chk("ldi_c2_state", int'(state), int'(S_DECODE));
    chk("ldi_c2_ctrl", int'(ctrl), 0);
    @(negedge clk);
    chk("ldi_c3_state", int'(state), int'(S_LDI));
    chk("ldi_c3_ld_di", int'(ctrl.ld_di), 1);
    chk("ldi_c3_done", int'(instr_done), 1);
    @(negedge clk);
    chk("ldi_c4_state", int'(state), int'(S_FETCH));
    chk("ldi_c4_done", int'(instr_done), 0);

    // FETCH held by memory wait, then ADA
    dir_ready = 1'b0;
    instr = {4'b0110, 2'b01};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_state", int'(state), int'(S_FETCH));
      chk("wait_ld_ir", int'(ctrl.ld_ir), 0);
      chk("wait_ld_pc", int'(ctrl.ld_pc), 0);
      @(negedge clk);
    end
    dir_ready = 1'b1;
    #1;
    chk("wait_4th_ld_ir", int'(ctrl.ld_ir), 1);
    @(negedge clk);
    chk("ada_decode", int'(state), int'(S_DECODE));
    @(negedge clk);
    chk("ada_fetch2", int'(state), int'(S_FETCH2));
    chk("ada_f2_ld_tr", int'(ctrl.ld_tr), 1);
    chk("ada_f2_rf_we", int'(ctrl.rf_we), 0);
    @(negedge clk);
    chk("ada_ld_mem", int'(state), int'(S_LD_MEM));
    chk("ada_lm_ld_tr", int'(ctrl.ld_tr), 1);
    chk("ada_lm_addr_tr", int'(ctrl.mem_addr_sel), 1);
    @(negedge clk);
    chk("ada_alu_mem", int'(state), int'(S_ALU_MEM));
    chk("ada_am_ld_alu", int'(ctrl.ld_alu), 1);
    chk("ada_am_alu_op", int'(ctrl.alu_op), 0);
    chk("ada_am_rf_we", int'(ctrl.rf_we), 0);
    @(negedge clk);
    chk("ada_mem_wb", int'(state), int'(S_MEM_WB));
    chk("ada_wb_rf_we", int'(ctrl.rf_we), 1);
    chk("ada_wb_done", int'(instr_done), 1);

    // JMP not taken, then taken
    @(negedge clk);
    instr = {4'b1010, 2'b10};
    jump_cond = 1'b0;
    repeat (3) @(negedge clk);
    chk("jmp0_state", int'(state), int'(S_JMP));
    chk("jmp0_ld_pc", int'(ctrl.ld_pc), 0);
    chk("jmp0_done", int'(instr_done), 1);
    @(negedge clk);
    jump_cond = 1'b1;
    repeat (3) @(negedge clk);
    chk("jmp1_ld_pc", int'(ctrl.ld_pc), 1);
    chk("jmp1_pc_sel", int'(ctrl.pc_sel), 1);

    // Illegal opcode
    @(negedge clk);
    instr = {4'b1111, 2'b00};
    repeat (2) @(negedge clk);
    chk("ill_state", int'(state), int'(S_ILLEGAL));
    chk("ill_pulse", int'(illegal_op), 1);
    chk("ill_ctrl", int'(ctrl), 0);
    @(negedge clk);
    chk("ill_back_fetch", int'(state), int'(S_FETCH));
    chk("ill_pulse_end", int'(illegal_op), 0);

    // Reset in the middle of a stalled STA
    instr = {4'b0101, 2'b01};
    repeat (3) @(negedge clk);
    dir_ready = 1'b0;
    #1;
    chk("sta_state", int'(state), int'(S_STA));
    chk("sta_mem_wr", int'(ctrl.mem_wr), 1);
    chk("sta_no_done", int'(instr_done), 0);
    @(negedge clk);
    chk("sta_held", int'(state), int'(S_STA));
    rst = 1'b1;
    #1;
    chk("sta_rst_state", int'(state), int'(S_FETCH));
    chk("sta_rst_mem_wr", int'(ctrl.mem_wr), 0);
    chk("sta_rst_err", int'(err), 0);
    @(negedge clk);
    chk("sta_rst_state2", int'(state), int'(S_FETCH));
    chk("sta_rst_mem_wr2", int'(ctrl.mem_wr), 0);

    // WAIT_MAX+1 wait cycles -> ERROR, sticky until reset
    rst = 1'b0;
    for (int i = 0; i <= WM; i++) begin
      #1;
      chk("to_state", int'(state), int'(S_FETCH));
      chk("to_err", int'(err), 0);
      @(negedge clk);
    end
    chk("to_error_state", int'(state), int'(S_ERROR));
    chk("to_err_set", int'(err), 1);
    chk("to_ctrl", int'(ctrl), 0);
    dir_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", int'(err), 1);
    chk("to_state_sticky", int'(state), int'(S_ERROR));

    // Ready on the limit cycle wins
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clears_err", int'(err), 0);
    dir_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < WM; i++) begin
      #1;
      chk("lim_state", int'(state), int'(S_FETCH));
      @(negedge clk);
    end
    dir_ready = 1'b1;
    #1;
    chk("lim_ready_ld_ir", int'(ctrl.ld_ir), 1);
    @(negedge clk);
    chk("lim_decode", int'(state), int'(S_DECODE));
    chk("lim_err", int'(err), 0);

    // Random instruction stream with variable memory latency
    rst = 1'b1;
    @(negedge clk);
    mm_en = 1'b1;
    mm_busy = 1'b0;
    mm_rem = 0;
    issue();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 1; k < NI; k++) begin
      wait_done();
      issue();
    end
    wait_done();
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_queue_empty", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
